// File: rtl/dptr_multiciclo.sv
// Multicycle datapath: register bank, ALU, data memory and control FSM; one instruction per handshake.
// Optional iterative shift-add multiplier enabled by defining DPTR_MULT_EN.
//
// state | meaning
// IDLE  | ready for a new instruction
// DEC   | read operands, sign-extend immediate, classify
// EXE   | ALU result or effective address into alu_out
// MULT  | one shift-add step per cycle (DPTR_MULT_EN only)
// MEMA  | store write or load read into mdr
// WB    | done pulse, register write at the closing edge
module dptr_multiciclo #(
    parameter int DATA_W    = 32,
    parameter int REG_N     = 32,
    parameter int MEM_DEPTH = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         instr_valid,
    output logic                         instr_ready,
    input  logic [31:0]                  instruccion,
    output logic                         busy,
    output logic                         done,
    output logic                         illegal,
    output logic                         wb_en,
    output logic [4:0]                   wb_addr,
    output logic [DATA_W-1:0]            wb_data,
    output logic                         mem_we,
    output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
    output logic [DATA_W-1:0]            mem_wdata
);
    localparam int MA_W = $clog2(MEM_DEPTH);
    localparam int RA_W = (REG_N > 1) ? $clog2(REG_N) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DEC  = 3'd1,
        S_EXE  = 3'd2,
        S_MEMA = 3'd3,
        S_WB   = 3'd4
`ifdef DPTR_MULT_EN
        , S_MULT = 3'd5
`endif
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL,
        OP_ADDI, OP_LW, OP_SW, OP_ILL
    } op_t;

    state_t state, state_nx;
    op_t    op_dec, op_q;

    logic [31:0]       ir;
    logic [DATA_W-1:0] a, b, imm_q, alu_out, mdr;
    logic [DATA_W-1:0] rf  [REG_N];
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [4:0]        dest;
    logic [DATA_W-1:0] result;
    logic              writes;
    logic [DATA_W-1:0] rs_val, rt_val;

`ifdef DPTR_MULT_EN
    localparam int CNT_W = $clog2(DATA_W);
    logic [CNT_W-1:0] cnt;
`endif

    always_comb begin
        op_dec = OP_ILL;
        case (ir[31:26])
            6'b000000: begin
                case (ir[5:0])
                    6'b100000: op_dec = OP_ADD;
                    6'b100010: op_dec = OP_SUB;
                    6'b100100: op_dec = OP_AND;
                    6'b100101: op_dec = OP_OR;
                    6'b101010: op_dec = OP_SLT;
`ifdef DPTR_MULT_EN
                    6'b011000: op_dec = OP_MUL;
`endif
                    default:   op_dec = OP_ILL;
                endcase
            end
            6'b001000: op_dec = OP_ADDI;
            6'b100011: op_dec = OP_LW;
            6'b101011: op_dec = OP_SW;
            default:   op_dec = OP_ILL;
        endcase
    end

    // Registers at or beyond REG_N read as zero.
    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (int'(ir[25:21]) < REG_N) rs_val = rf[ir[21+RA_W-1:21]];
        if (int'(ir[20:16]) < REG_N) rt_val = rf[ir[16+RA_W-1:16]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (instr_valid) state_nx = S_DEC;
            S_DEC:  state_nx = (op_dec == OP_ILL) ? S_WB : S_EXE;
            S_EXE: begin
                if (op_q == OP_LW || op_q == OP_SW) state_nx = S_MEMA;
`ifdef DPTR_MULT_EN
                else if (op_q == OP_MUL)            state_nx = S_MULT;
`endif
                else                                state_nx = S_WB;
            end
`ifdef DPTR_MULT_EN
            S_MULT: if (cnt == '0) state_nx = S_WB;
`endif
            S_MEMA: state_nx = S_WB;
            S_WB:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state == S_IDLE);
        busy        = (state != S_IDLE);
        done        = (state == S_WB);
        illegal     = done && (op_q == OP_ILL);
        writes      = (op_q != OP_SW) && (op_q != OP_ILL);
        dest        = (op_q == OP_ADDI || op_q == OP_LW) ? ir[20:16] : ir[15:11];
        result      = (op_q == OP_LW) ? mdr : alu_out;
        wb_en       = done && writes && (dest != 5'd0) && (int'(dest) < REG_N);
        wb_addr     = done ? dest : 5'd0;
        wb_data     = done ? result : '0;
        mem_we      = (state == S_MEMA) && (op_q == OP_SW);
        mem_addr    = mem_we ? alu_out[MA_W-1:0] : '0;
        mem_wdata   = mem_we ? b : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            imm_q   <= '0;
            alu_out <= '0;
            mdr     <= '0;
            op_q    <= OP_ADD;
`ifdef DPTR_MULT_EN
            cnt     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (instr_valid) ir <= instruccion;
                S_DEC: begin
                    a     <= rs_val;
                    b     <= rt_val;
                    imm_q <= DATA_W'($signed(ir[15:0]));
                    op_q  <= op_dec;
                end
                S_EXE: begin
                    case (op_q)
                        OP_ADD: alu_out <= a + b;
                        OP_SUB: alu_out <= a - b;
                        OP_AND: alu_out <= a & b;
                        OP_OR:  alu_out <= a | b;
                        OP_SLT: alu_out <= ($signed(a) < $signed(b)) ? DATA_W'(1) : '0;
                        OP_ADDI, OP_LW, OP_SW: alu_out <= a + imm_q;
`ifdef DPTR_MULT_EN
                        OP_MUL: begin
                            alu_out <= '0;
                            cnt     <= CNT_W'(DATA_W - 1);
                        end
`endif
                        default: alu_out <= '0;
                    endcase
                end
`ifdef DPTR_MULT_EN
                // a shifts left as multiplicand, b shifts right as multiplier
                S_MULT: begin
                    alu_out <= alu_out + (b[0] ? a : '0);
                    a       <= a << 1;
                    b       <= b >> 1;
                    cnt     <= cnt - 1'b1;
                end
`endif
                S_MEMA: mdr <= mem[alu_out[MA_W-1:0]];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_N; i++) rf[i] <= '0;
        end else if (wb_en) begin
            rf[dest[RA_W-1:0]] <= result;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end
endmodule

// File: doc/dptr_multiciclo.md
# dptr_multiciclo

Parametrised multicycle successor to the single-cycle R-type datapath. Accepts one 32-bit instruction per valid/ready handshake and sequences it through decode, execute, optional memory access and write-back. Contains its own register bank, ALU, data memory and control FSM. Adds I-type `addi`/`lw`/`sw`, illegal-instruction reporting and an optional iterative multiplier. It is the core execution engine under a future fetch unit.

## Interface
- `DATA_W`, 32: datapath and register width; must be ≥ 16.
- `REG_N`, 32: number of registers, 2..32; register addresses ≥ `REG_N` read 0 and ignore writes.
- `MEM_DEPTH`, 256: data memory words; power of two.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr_valid` in 1: `instruccion` holds a valid instruction.
- `instr_ready` out 1: block can accept an instruction (IDLE).
- `instruccion` in 32: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0].
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse in WB.
- `illegal` out 1: pulses with `done` for unsupported encodings.
- `wb_en` out 1: register written at the end of this cycle.
- `wb_addr` out 5: destination register.
- `wb_data` out `DATA_W`: value written.
- `mem_we` out 1: data-memory write this cycle.
- `mem_addr` out log2(`MEM_DEPTH`): word index.
- `mem_wdata` out `DATA_W`: store data.

## Operation
- Supported instructions:
  - opcode 000000, funct 100000 `add`.
  - 100010 `sub`.
  - 100100 `and`.
  - 100101 `or`.
  - 101010 `slt`: signed compare, result 1/0.
  - 011000 `mul`: only with the macro.
  - Opcode 001000 `addi`: rt = rs + sext(imm).
  - Opcode 100011 `lw`: rt = MEM[ea].
  - Opcode 101011 `sw`: MEM[ea] = rt.
  - Every other opcode/funct is illegal.
- ea = rs + sext(imm). Word-addressed; index = ea[log2(MEM_DEPTH)-1:0]; upper bits ignored.
- Arithmetic wraps modulo 2^DATA_W. `mul` keeps the low DATA_W bits of the product, which are sign-agnostic. Immediates are sign-extended from bit 15.
- Register 0 is hardwired to zero. Writes to it are dropped and `wb_en` stays 0.
- FSM states and transitions:
  - IDLE: `instr_ready`=1. On valid && ready, capture `instruccion` and go to DEC.
  - DEC: latch A=R[rs], B=R[rt] and sext(imm); classify. Illegal → WB. Otherwise → EXE.
  - EXE: compute ALU result or ea into `alu_out`. `mul` → MULT. `lw`/`sw` → MEMA. Otherwise → WB.
  - MULT: shift-add one bit per cycle for DATA_W cycles, then → WB.
  - MEMA: `sw` asserts `mem_we` for this cycle; `lw` reads the memory into `mdr`. Then → WB.
  - WB: `done`=1. The register write happens at the closing edge (not for `sw` or illegal). Then → IDLE.
- `instr_valid` is ignored while not in IDLE; the instruction is not queued.
- On reset: state IDLE, all registers 0, internal latches 0. Memory contents are not reset.

## Timing
- Output values during reset: `instr_ready`=1; `busy`, `done`, `illegal`, `wb_en`, `mem_we` = 0; `wb_addr`, `wb_data`, `mem_addr`, `mem_wdata` = 0.
- Latency is measured from the accepting edge to the cycle in which `done` is high:
  - R-type and `addi`: 3.
  - `lw` and `sw`: 4.
  - `mul`: 3 + DATA_W.
  - Illegal: 2.
- Throughput: the next instruction can be accepted the cycle after WB. R-type issue interval is 4 cycles.
- `wb_*` outputs are valid only while `done`=1, and are 0 otherwise. `mem_*` outputs are valid only while `mem_we`=1, and are 0 otherwise.
- Reset mid-operation takes effect asynchronously:
  - The in-flight instruction is abandoned with no register write.
  - A memory write completes only if its edge precedes the reset assertion.

## Configuration
- `DPTR_MULT_EN` defined:
  - funct 011000 executes through MULT.
  - `busy` is held for the DATA_W iteration cycles.
- `DPTR_MULT_EN` undefined:
  - No multiplier logic or MULT state exists.
  - funct 011000 is illegal: 2-cycle latency, `illegal`=1, no write.

## Test plan
- Reset, then `addi $1,$0,5`; `addi $2,$0,-3`; `add $3,$1,$2` → `wb_addr`=3, `wb_data`=2, `done` 3 cycles after acceptance.
- `sub $4,$2,$1` → 0xFFFFFFF8; `slt $5,$2,$1` → 1; `slt $5,$1,$2` → 0; `add $0,$1,$1` → `done`=1, `wb_en`=0, R0 stays 0.
- `sw $1,4($0)` → `mem_we`=1 with `mem_addr`=4, `mem_wdata`=5; then `lw $6,4($0)` → `wb_data`=5; both with latency 4. `sw $1,260($0)` with MEM_DEPTH=256 → `mem_addr`=4.
- Opcode 000010 → `done`=`illegal`=1 at 2 cycles, `wb_en`=0; `instr_valid` pulsed while busy is ignored (no extra `done`).
- With `DPTR_MULT_EN`: `addi $7,$0,7`; `mul $8,$7,$2` → 0xFFFFFFEB at latency 35. Without the macro: `illegal`=1 at latency 2.
- Assert `rst_n`=0 during EXE of `add $9,$1,$1` → `instr_ready`=1 and `done`=0 immediately; after release, `add $9,$1,$1` → 0.
